// File: rtl/axi_lite_master_pkg.sv
// Shared AXI-Lite definitions for the command-to-AXI-Lite bridge.
package axi_lite_master_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_timeout.sv
// Saturating outstanding-cycle counter with a sticky flag; TIMEOUT_CYCLES = 0 disables it.
module axi_lite_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic flag
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);
  localparam bit Enabled = (TIMEOUT_CYCLES != 0);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      flag  <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      flag  <= 1'b0;
    end else if (Enabled && en && (cnt_q != Limit)) begin
      cnt_q <= cnt_inc;
      if (cnt_inc == Limit) flag <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding command/response strobe interface to AXI-Lite initiator.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cmd_stb,
  output logic                  o_cmd_rdy,
  input  logic                  i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_data,
  input  logic [3:0]            i_cmd_strb,
  output logic                  o_rsp_stb,
  output logic [31:0]           o_rsp_data,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_timeout,
  output logic                  o_awvalid,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  input  logic                  i_awready,
  output logic                  o_wvalid,
  output logic [31:0]           o_wdata,
  output logic [3:0]            o_wstrb,
  input  logic                  i_wready,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [31:0]           i_rdata,
  input  logic [1:0]            i_rresp
);

  typedef enum logic [2:0] {StIdle, StWrAddrData, StWrResp, StRdAddr, StRdData} state_e;

  state_e state_q;
  logic   accept;
  logic   aw_pending;
  logic   w_pending;

  assign accept = i_cmd_stb && o_cmd_rdy;
  // A channel still owes a handshake if its valid is up and the slave is not taking it now.
  assign aw_pending = o_awvalid && !i_awready;
  assign w_pending  = o_wvalid && !i_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      o_cmd_rdy  <= 1'b1;
      o_rsp_stb  <= 1'b0;
      o_rsp_data <= '0;
      o_rsp_resp <= AXI_RESP_OKAY;
      o_awvalid  <= 1'b0;
      o_awaddr   <= '0;
      o_wvalid   <= 1'b0;
      o_wdata    <= '0;
      o_wstrb    <= '0;
      o_bready   <= 1'b0;
      o_arvalid  <= 1'b0;
      o_araddr   <= '0;
      o_rready   <= 1'b0;
    end else begin
      o_rsp_stb <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            o_cmd_rdy <= 1'b0;
            if (i_cmd_wr) begin
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
              o_awaddr  <= i_cmd_addr;
              o_wdata   <= i_cmd_data;
              o_wstrb   <= i_cmd_strb;
              state_q   <= StWrAddrData;
            end else begin
              o_arvalid <= 1'b1;
              o_araddr  <= i_cmd_addr;
              state_q   <= StRdAddr;
            end
          end
        end
        StWrAddrData: begin
          if (o_awvalid && i_awready) o_awvalid <= 1'b0;
          if (o_wvalid && i_wready)   o_wvalid  <= 1'b0;
          if (!aw_pending && !w_pending) begin
            o_bready <= 1'b1;
            state_q  <= StWrResp;
          end
        end
        StWrResp: begin
          if (i_bvalid && o_bready) begin
            o_bready   <= 1'b0;
            o_rsp_resp <= i_bresp;
            o_rsp_stb  <= 1'b1;
            o_cmd_rdy  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StRdAddr: begin
          if (i_arready && o_arvalid) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (i_rvalid && o_rready) begin
            o_rready   <= 1'b0;
            o_rsp_data <= i_rdata;
            o_rsp_resp <= i_rresp;
            o_rsp_stb  <= 1'b1;
            o_cmd_rdy  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axi_lite_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state_q != StIdle),
    .flag (o_timeout)
  );

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench: an in-bench AXI-Lite slave with per-channel delays and a cycle-level model.
module tb_axi_lite_master;
  import axi_lite_master_pkg::*;

  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cmd_stb, o_cmd_rdy, i_cmd_wr;
  logic [AW-1:0] i_cmd_addr;
  logic [31:0]   i_cmd_data;
  logic [3:0]    i_cmd_strb;
  logic          o_rsp_stb;
  logic [31:0]   o_rsp_data;
  logic [1:0]    o_rsp_resp;
  logic          o_timeout;
  logic          o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic [31:0]   o_wdata, i_rdata;
  logic [3:0]    o_wstrb;
  logic [1:0]    i_bresp, i_rresp;
  logic          o_arvalid, i_arready, i_rvalid, o_rready;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          last_rsp_cyc = 0;
  logic [31:0] last_rdata;

  axi_lite_master #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cmd_stb (i_cmd_stb),
    .o_cmd_rdy (o_cmd_rdy),
    .i_cmd_wr  (i_cmd_wr),
    .i_cmd_addr(i_cmd_addr),
    .i_cmd_data(i_cmd_data),
    .i_cmd_strb(i_cmd_strb),
    .o_rsp_stb (o_rsp_stb),
    .o_rsp_data(o_rsp_data),
    .o_rsp_resp(o_rsp_resp),
    .o_timeout (o_timeout),
    .o_awvalid (o_awvalid),
    .o_awaddr  (o_awaddr),
    .i_awready (i_awready),
    .o_wvalid  (o_wvalid),
    .o_wdata   (o_wdata),
    .o_wstrb   (o_wstrb),
    .i_wready  (i_wready),
    .i_bvalid  (i_bvalid),
    .o_bready  (o_bready),
    .i_bresp   (i_bresp),
    .o_arvalid (o_arvalid),
    .o_araddr  (o_araddr),
    .i_arready (i_arready),
    .i_rvalid  (i_rvalid),
    .o_rready  (o_rready),
    .i_rdata   (i_rdata),
    .i_rresp   (i_rresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ctl_vec();
    return {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_cmd_rdy, o_rsp_stb, o_timeout};
  endfunction

  task automatic slave_idle();
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
    i_arready = 1'b0; i_rvalid = 1'b0;
  endtask

  // One transaction end to end: every cycle the expected control outputs follow from which
  // handshakes the slave model has completed and how long the command has been outstanding.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_dly, input int w_dly,
                         input int b_dly, input int ar_dly, input int r_dly,
                         input logic [1:0] resp, input logic [31:0] rdata,
                         input bit b2b, input int exp_lat);
    int acc;
    int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0;
    bit aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0, fin, done = 0;
    logic [7:0] exp_v;
    for (int i = 0; i < 200 && !o_cmd_rdy; i++) @(negedge clk);
    check("cmd_rdy", 32'(o_cmd_rdy), 32'd1);
    if (b2b) check("b2b_accept_cycle", 32'(cyc), 32'(last_rsp_cyc));
    i_cmd_stb = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_data = data; i_cmd_strb = strb;
    acc = cyc;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      fin = wr ? b_d : r_d;
      exp_v = {wr && !aw_d, wr && !w_d, wr && aw_d && w_d && !b_d, !wr && !ar_d,
               !wr && ar_d && !r_d, fin, fin, (cyc - acc - 1) >= TO};
      check(wr ? "wr_ctl" : "rd_ctl", 32'(ctl_vec()), 32'(exp_v));
      if (fin) begin
        slave_idle();
        i_cmd_stb = 1'b0;
        if (!wr) last_rdata = rdata;
        check("rsp_resp", 32'(o_rsp_resp), 32'(resp));
        check("rsp_data", o_rsp_data, last_rdata);
        if (exp_lat != 0) check("latency", 32'(cyc - acc), 32'(exp_lat));
        last_rsp_cyc = cyc;
        done = 1;
      end else begin
        // Busy: throw junk at the command port, it must be ignored.
        i_cmd_stb = 1'($urandom); i_cmd_wr = 1'($urandom);
        i_cmd_addr = AW'($urandom); i_cmd_data = $urandom; i_cmd_strb = 4'($urandom);
        // B and R are decided from handshakes completed at earlier edges only.
        i_bvalid = wr && aw_d && w_d && !b_d && (b_w >= b_dly);
        i_bresp  = resp;
        if (wr && aw_d && w_d && !b_d) begin
          if (i_bvalid && o_bready) b_d = 1; else b_w++;
        end
        i_rvalid = !wr && ar_d && !r_d && (r_w >= r_dly);
        i_rdata  = i_rvalid ? rdata : $urandom;
        i_rresp  = resp;
        if (!wr && ar_d && !r_d) begin
          if (i_rvalid && o_rready) r_d = 1; else r_w++;
        end
        i_awready = wr && !aw_d && (aw_w >= aw_dly);
        if (wr && !aw_d) begin
          if (i_awready && o_awvalid) begin
            check("awaddr", 32'(o_awaddr), 32'(addr));
            aw_d = 1;
          end else aw_w++;
        end
        i_wready = wr && !w_d && (w_w >= w_dly);
        if (wr && !w_d) begin
          if (i_wready && o_wvalid) begin
            check("wdata", o_wdata, data);
            check("wstrb", 32'(o_wstrb), 32'(strb));
            w_d = 1;
          end else w_w++;
        end
        i_arready = !wr && !ar_d && (ar_w >= ar_dly);
        if (!wr && !ar_d) begin
          if (i_arready && o_arvalid) begin
            check("araddr", 32'(o_araddr), 32'(addr));
            ar_d = 1;
          end else ar_w++;
        end
      end
    end
    if (!done) check("txn_bound", 32'd0, 32'd1);
  endtask

  function automatic int rnd_dly();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 10)) : int'($urandom_range(0, 2));
  endfunction

  initial begin
    rst_n = 1'b0;
    i_cmd_stb = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_data = '0; i_cmd_strb = '0;
    i_bresp = '0; i_rresp = '0; i_rdata = '0;
    slave_idle();
    last_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ctl", 32'(ctl_vec()), 32'h04);
    check("reset_awaddr", 32'(o_awaddr), 32'd0);
    check("reset_rsp_data", o_rsp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Always-ready write, minimum latency.
    run_txn(1, 16'h1234, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, AXI_RESP_OKAY, 32'd0, 0, 3);
    @(negedge clk);
    // Read with 5 wait cycles before RVALID and a DECERR response.
    run_txn(0, 16'h0040, 32'd0, 4'h0, 0, 0, 0, 0, 5, AXI_RESP_DECERR, 32'hCAFEF00D, 0, 8);
    // W completes 4 cycles before AW, then the reverse.
    run_txn(1, 16'h0100, 32'h11112222, 4'h3, 4, 0, 1, 0, 0, AXI_RESP_SLVERR, 32'd0, 0, 0);
    run_txn(1, 16'h0104, 32'h33334444, 4'hC, 0, 4, 0, 0, 0, AXI_RESP_EXOKAY, 32'd0, 1, 0);
    // Back-to-back read then write.
    run_txn(0, 16'h0200, 32'd0, 4'h0, 1, 1, 1, 1, 1, AXI_RESP_OKAY, 32'h0BADF00D, 1, 0);
    run_txn(1, 16'h0204, 32'h55667788, 4'hF, 0, 0, 0, 0, 0, AXI_RESP_OKAY, 32'd0, 1, 3);
    // Stalled AR long enough to trip the timeout; following command clears it.
    run_txn(0, 16'h0300, 32'd0, 4'h0, 0, 0, 0, 20, 1, AXI_RESP_OKAY, 32'h12345678, 1, 0);
    run_txn(1, 16'h0304, 32'h9ABCDEF0, 4'h5, 0, 0, 0, 0, 0, AXI_RESP_OKAY, 32'd0, 1, 3);

    // Reset pulsed while waiting in the write-response phase.
    @(negedge clk);
    i_cmd_stb = 1'b1; i_cmd_wr = 1'b1; i_cmd_addr = 16'h0400; i_cmd_data = 32'hFEEDFACE;
    i_cmd_strb = 4'hF; i_awready = 1'b1; i_wready = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    @(negedge clk);
    check("wr_resp_bready", 32'(o_bready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctl", 32'(ctl_vec()), 32'h04);
    check("async_reset_awaddr", 32'(o_awaddr), 32'd0);
    check("async_reset_wdata", o_wdata, 32'd0);
    check("async_reset_wstrb", 32'(o_wstrb), 32'd0);
    check("async_reset_rsp", {o_rsp_data[29:0], o_rsp_resp}, 32'd0);
    i_bvalid = 1'b1; i_bresp = AXI_RESP_SLVERR;
    repeat (2) begin
      @(negedge clk);
      check("no_rsp_in_reset", 32'(o_rsp_stb), 32'd0);
    end
    slave_idle();
    rst_n = 1'b1;
    last_rdata = '0;
    @(negedge clk);
    check("post_reset_idle", 32'({o_cmd_rdy, o_rsp_stb, o_bready}), 32'h4);
    run_txn(0, 16'h0500, 32'd0, 4'h0, 0, 0, 0, 0, 0, AXI_RESP_OKAY, 32'hA5A55A5A, 0, 3);

    // Randomized traffic, mixing back-to-back issue and idle gaps.
    for (int t = 0; t < 40; t++) begin
      bit b2b = 1'($urandom);
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_txn(1'($urandom), AW'($urandom), $urandom, 4'($urandom), rnd_dly(), rnd_dly(),
              rnd_dly(), rnd_dly(), rnd_dly(), 2'($urandom), $urandom, b2b, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
